reg_disp_scan: RTL

- Reader for the MIPS register-file diagnosis port (dispSel/dispDat).
- Drives the register select, snapshots the returned 32-bit value once per display frame, and shows one 16-bit half on the board's 4-digit multiplexed active-low seven-segment display.
- Register selection comes from switches, or from an auto-scan that steps through $0..$31.
- Sits at top level beside clk_gen and mips and runs on the same clock as the snapshot logic.

---
 rtl/reg_disp_scan.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/reg_disp_scan.sv
// Register-file diagnosis reader: snapshots one CPU register per display
// frame and shows a 16-bit half on a 4-digit multiplexed 7-segment display.
module reg_disp_scan #(
    parameter int DIGIT_CYCLES = 12500,
    parameter int AUTO_CYCLES  = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  sw_sel,
    input  logic        sw_half,
    input  logic        auto_en,
    input  logic        freeze,
    output logic [4:0]  disp_sel,
    input  logic [31:0] disp_dat,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [4:0]  cur_reg
);

    localparam int DW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int AW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
    localparam logic [DW-1:0] DIG_LAST  = DW'(DIGIT_CYCLES - 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SEL,
        S_CAP,
        S_HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic [4:0]    areg_q, areg_d;
    logic [4:0]    sel_q, sel_d;
    logic [4:0]    cur_q, cur_d;
    logic [31:0]   snap_q, snap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          dig_wrap;
    logic          frame_tick;
    logic [4:0]    target;
    logic [15:0]   half;
    logic [3:0]    nib;

    assign dig_wrap   = (dcnt_q == DIG_LAST);
    assign frame_tick = dig_wrap && (dig_q == 2'd3);
    assign target     = auto_en ? areg_q : sw_sel;

    always_comb begin
        dcnt_d = dcnt_q + DW'(1);
        dig_d  = dig_q;
        if (dig_wrap) begin
            dcnt_d = '0;
            dig_d  = dig_q + 2'd1;
        end
        acnt_d = acnt_q;
        areg_d = areg_q;
        if (auto_en) begin
            if (acnt_q == AUTO_LAST) begin
                acnt_d = '0;
                areg_d = areg_q + 5'd1;
            end else begin
                acnt_d = acnt_q + AW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cur_d   = cur_q;
        snap_d  = snap_q;
        unique case (state_q)
            S_SEL: begin
                sel_d   = target;
                state_d = S_CAP;
            end
            S_CAP: begin
                snap_d  = disp_dat;
                cur_d   = sel_q;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (frame_tick && !freeze)
                    state_d = S_SEL;
            end
            default: state_d = S_SEL;
        endcase
    end

    // Display registers follow the digit index one cycle behind
    always_comb begin
        half = sw_half ? snap_q[31:16] : snap_q[15:0];
        nib  = 4'h0;
        unique case (dig_q)
            2'd0: nib = half[3:0];
            2'd1: nib = half[7:4];
            2'd2: nib = half[11:8];
            2'd3: nib = half[15:12];
            default: nib = 4'h0;
        endcase
        seg_d = 7'b1111111;
        unique case (nib)
            4'h0: seg_d = 7'b1000000;
            4'h1: seg_d = 7'b1111001;
            4'h2: seg_d = 7'b0100100;
            4'h3: seg_d = 7'b0110000;
            4'h4: seg_d = 7'b0011001;
            4'h5: seg_d = 7'b0010010;
            4'h6: seg_d = 7'b0000010;
            4'h7: seg_d = 7'b1111000;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0010000;
            4'hA: seg_d = 7'b0001000;
            4'hB: seg_d = 7'b0000011;
            4'hC: seg_d = 7'b1000110;
            4'hD: seg_d = 7'b0100001;
            4'hE: seg_d = 7'b0000110;
            4'hF: seg_d = 7'b0001110;
            default: seg_d = 7'b1111111;
        endcase
        an_d = ~(4'b0001 << dig_q);
        dp_d = !(sw_half && (dig_q == 2'd3));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_SEL;
            dcnt_q  <= '0;
            dig_q   <= 2'd0;
            acnt_q  <= '0;
            areg_q  <= 5'd0;
            sel_q   <= 5'd0;
            cur_q   <= 5'd0;
            snap_q  <= 32'd0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            dig_q   <= dig_d;
            acnt_q  <= acnt_d;
            areg_q  <= areg_d;
            sel_q   <= sel_d;
            cur_q   <= cur_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign disp_sel = sel_q;
    assign cur_reg  = cur_q;
    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;

endmodule
